// File: rtl/quad_decoder_updown_if.sv
// Encoder-side bundle for quad_decoder_updown: phase inputs, controls and count outputs.
// Latency: n/a (wires only).
// Backpressure: none; the encoder phases are free-running and cannot be stalled.
interface quad_decoder_updown_if #(
    parameter int WIDTH = 8
);
    logic             qa;
    logic             qb;
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] cnt;
    logic             step;
    logic             dir;
    logic             wrap;
    logic             err;

    // Stimulus / consumer side
    modport master (
        output qa, qb, en, clr,
        input  cnt, step, dir, wrap, err
    );

    // Decoder side
    modport slave (
        input  qa, qb, en, clr,
        output cnt, step, dir, wrap, err
    );
endinterface

// File: rtl/quad_decoder_updown.sv
// Quadrature decoder: synchronizes qa/qb, decodes Gray steps into step/dir and a wrapping count.
// Latency: SYNC_STAGES+1 cycles from phase edge to step/cnt (SYNC_STAGES+FILT_LEN+1 with QDEC_FILTER_EN).
// Backpressure: none; one edge accepted per cycle, too-fast or two-bit changes flag the sticky err.
module quad_decoder_updown #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3   // >=2, used only with QDEC_FILTER_EN
) (
    input  logic                 clock,
    input  logic                 rst,
    quad_decoder_updown_if.slave bus
);
    localparam logic [0:0] ARM   = 1'b0;
    localparam logic [0:0] TRACK = 1'b1;

`ifdef QDEC_FILTER_EN
    localparam int FILT_LAT = FILT_LEN;
`else
    // Without the filter the sample path adds no cycles beyond the synchronizer.
    localparam int FILT_LAT = 0 * FILT_LEN;
`endif
    // Cycles until the sample path holds real pin values rather than reset zeros.
    localparam int          PRIME   = SYNC_STAGES + FILT_LAT;
    localparam logic [7:0]  PRIME_C = 8'(PRIME);

    logic [1:0]       sync_q [SYNC_STAGES];
    logic [1:0]       s_sync;
    logic [1:0]       s;
    logic [1:0]       prev_q;
    logic [0:0]       state_q;
    logic [7:0]       fill_q;
    logic [WIDTH-1:0] cnt_q;
    logic             step_q;
    logic             dir_q;
    logic             wrap_q;
    logic             err_q;
    logic [1:0]       delta;

    // Position of a phase pair along the up sequence 00->01->11->10.
    function automatic logic [1:0] phase_pos(input logic [1:0] v);
        case (v)
            2'b00:   phase_pos = 2'd0;
            2'b01:   phase_pos = 2'd1;
            2'b11:   phase_pos = 2'd2;
            default: phase_pos = 2'd3;
        endcase
    endfunction

    // Metastability synchronizer for both phases
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b00;
        end else begin
            sync_q[0] <= {bus.qa, bus.qb};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s_sync = sync_q[SYNC_STAGES-1];

`ifdef QDEC_FILTER_EN
    logic [1:0] hist_q [FILT_LEN-1];
    logic [1:0] filt_q;
    logic [1:0] stable;

    // A phase is stable when the current synchronized sample matches the previous FILT_LEN-1
    always_comb begin
        stable = 2'b11;
        for (int i = 0; i < FILT_LEN-1; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (hist_q[i][p] != s_sync[p]) stable[p] = 1'b0;
            end
        end
    end

    // Sample history and per-phase filtered value
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FILT_LEN-1; i++) hist_q[i] <= 2'b00;
            filt_q <= 2'b00;
        end else begin
            hist_q[0] <= s_sync;
            for (int i = 1; i < FILT_LEN-1; i++) hist_q[i] <= hist_q[i-1];
            for (int p = 0; p < 2; p++) begin
                if (stable[p]) filt_q[p] <= s_sync[p];
            end
        end
    end

    assign s = filt_q;
`else
    assign s = s_sync;
`endif

    // Step distance from the last accepted sample: 1 = up, 3 = down, 2 = illegal jump
    always_comb begin
        delta = phase_pos(s) - phase_pos(prev_q);
    end

    // Arm/track sequencing, count, direction, pulses and sticky error
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= ARM;
            fill_q  <= 8'd0;
            prev_q  <= 2'b00;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b1;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            step_q <= 1'b0;
            wrap_q <= 1'b0;
            // Every sample is consumed, whether counted, suppressed or flagged.
            prev_q <= s;
            // Stay armed until the sample path is primed, so the reset zeros
            // of the synchronizer are never mistaken for a pin transition.
            if (state_q == ARM) begin
                if (fill_q == PRIME_C) state_q <= TRACK;
                else                   fill_q  <= fill_q + 8'd1;
            end
            if (bus.clr) begin
                cnt_q <= '0;
                err_q <= 1'b0;
            end else if (state_q == TRACK) begin
                case (delta)
                    2'd2: err_q <= 1'b1;
                    2'd1: begin
                        if (bus.en) begin
                            step_q <= 1'b1;
                            dir_q  <= 1'b1;
                            wrap_q <= (cnt_q == {WIDTH{1'b1}});
                            cnt_q  <= cnt_q + 1'b1;
                        end
                    end
                    2'd3: begin
                        if (bus.en) begin
                            step_q <= 1'b1;
                            dir_q  <= 1'b0;
                            wrap_q <= (cnt_q == '0);
                            cnt_q  <= cnt_q - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.cnt  = cnt_q;
    assign bus.step = step_q;
    assign bus.dir  = dir_q;
    assign bus.wrap = wrap_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_quad_decoder_updown.sv
// Testbench for quad_decoder_updown: directed scenarios then a random encoder walk.
// Reference model tracks encoder position as an integer index and expected count arithmetically.
// Outputs are sampled on the falling clock edge; inputs change on the falling edge.
module tb_quad_decoder_updown;
    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int FILT  = 3;
    localparam int MAXC  = (1 << WIDTH) - 1;
`ifdef QDEC_FILTER_EN
    localparam int LAT = SYNC + FILT + 1;
`else
    localparam int LAT = SYNC + 1;
`endif
    localparam int GAP = 10;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    quad_decoder_updown_if #(.WIDTH(WIDTH)) bus ();

    quad_decoder_updown #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC),
        .FILT_LEN   (FILT)
    ) dut (
        .clock(clock),
        .rst  (rst),
        .bus  (bus)
    );

    int   errors = 0;
    int   checks = 0;
    int   enc_idx;
    int   exp_cnt;
    logic exp_dir;
    logic exp_err;
    logic en_m;
    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_phase();
        bus.qa = gray[enc_idx][1];
        bus.qb = gray[enc_idx][0];
    endtask

    // Move the encoder by d positions (+-1 legal, +-2 illegal) and watch GAP cycles.
    task automatic move(input int d);
        logic es;
        logic ew;
        es = 1'b0;
        ew = 1'b0;
        enc_idx = (enc_idx + d + 4) % 4;
        drive_phase();
        if (d == 2 || d == -2) begin
            exp_err = 1'b1;
        end else if (en_m) begin
            es      = 1'b1;
            exp_dir = (d > 0);
            ew      = (d > 0) ? (exp_cnt == MAXC) : (exp_cnt == 0);
            exp_cnt = (exp_cnt + d + MAXC + 1) % (MAXC + 1);
        end
        for (int i = 1; i <= GAP; i++) begin
            @(negedge clock);
            if (i == LAT) begin
                check("step_at_lat", bus.step, es);
                check("wrap_at_lat", bus.wrap, ew);
                check("cnt_at_lat", bus.cnt, exp_cnt);
                check("dir_at_lat", bus.dir, exp_dir);
                check("err_at_lat", bus.err, exp_err);
            end else begin
                check("step_idle", bus.step, 1'b0);
                check("wrap_idle", bus.wrap, 1'b0);
            end
        end
    endtask

    task automatic clr_pulse();
        bus.clr = 1'b1;
        @(negedge clock);
        bus.clr = 1'b0;
        exp_cnt = 0;
        exp_err = 1'b0;
        check("clr_cnt", bus.cnt, 0);
        check("clr_err", bus.err, 1'b0);
        check("clr_step", bus.step, 1'b0);
        check("clr_dir", bus.dir, exp_dir);
    endtask

    initial begin
        bus.qa  = 1'b1;
        bus.qb  = 1'b1;
        bus.en  = 1'b1;
        bus.clr = 1'b0;
        enc_idx = 2;
        en_m    = 1'b1;
        exp_cnt = 0;
        exp_dir = 1'b1;
        exp_err = 1'b0;
        #1 rst = 1'b0;

        // Reset held for 3 cycles with both phases high
        repeat (3) @(negedge clock);
        check("rst_cnt", bus.cnt, 0);
        check("rst_step", bus.step, 1'b0);
        check("rst_dir", bus.dir, 1'b1);
        check("rst_wrap", bus.wrap, 1'b0);
        check("rst_err", bus.err, 1'b0);

        // Release: the arm period must not count or flag the held 11 sample
        rst = 1'b1;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clock);
            check("arm_step", bus.step, 1'b0);
            check("arm_err", bus.err, 1'b0);
            check("arm_cnt", bus.cnt, 0);
        end

        // Eight up edges
        repeat (8) move(1);
        check("up8_cnt", bus.cnt, 8);
        check("up8_dir", bus.dir, 1'b1);

        // Wrap down from zero, then back up across the boundary
        clr_pulse();
        move(-1);
        check("wrap_down_cnt", bus.cnt, MAXC);
        move(1);
        check("wrap_up_cnt", bus.cnt, 0);

        // Illegal two-bit jump, then clear
        move(1);
        move(2);
        check("jump_err", bus.err, 1'b1);
        check("jump_cnt", bus.cnt, 1);
        clr_pulse();

        // Counting disabled: phase tracked, nothing counted, no burst afterwards
        en_m = 1'b0;
        bus.en = 1'b0;
        repeat (4) move(1);
        check("en0_cnt", bus.cnt, 0);
        en_m = 1'b1;
        bus.en = 1'b1;
        move(1);
        check("en1_cnt", bus.cnt, 1);

        // Clear coinciding with an edge reaching the decoder: edge consumed, no step
        enc_idx = (enc_idx + 1) % 4;
        drive_phase();
        repeat (LAT - 1) @(negedge clock);
        bus.clr = 1'b1;
        @(negedge clock);
        bus.clr = 1'b0;
        exp_cnt = 0;
        exp_err = 1'b0;
        check("clr_edge_cnt", bus.cnt, 0);
        check("clr_edge_step", bus.step, 1'b0);
        check("clr_edge_dir", bus.dir, exp_dir);
        for (int i = 0; i < GAP; i++) begin
            @(negedge clock);
            check("clr_edge_after_step", bus.step, 1'b0);
        end

`ifdef QDEC_FILTER_EN
        // Two-cycle glitch on qa is filtered out
        bus.qa = ~bus.qa;
        repeat (2) @(negedge clock);
        bus.qa = ~bus.qa;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            check("glitch_step", bus.step, 1'b0);
            check("glitch_err", bus.err, 1'b0);
        end
        check("glitch_cnt", bus.cnt, 0);
        move(1);
`endif

        // Random walk with occasional enable toggles, clears and illegal jumps
        for (int n = 0; n < 120; n++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                move(($urandom_range(0, 1) == 1) ? 2 : -2);
            end else if (r <= 2) begin
                en_m = ~en_m;
                bus.en = en_m;
                @(negedge clock);
            end else if (r == 3) begin
                clr_pulse();
            end else begin
                move(($urandom_range(0, 1) == 1) ? 1 : -1);
            end
        end
        check("final_cnt", bus.cnt, exp_cnt);
        check("final_err", bus.err, exp_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
